// File: rtl/fx2_pkg.sv
// Shared constants for the FX2 slave-FIFO endpoint emulation.
package fx2_pkg;
    localparam logic [1:0] FADDR_EP2 = 2'b00;
    localparam logic [1:0] FADDR_EP6 = 2'b10;

    localparam int DEF_DW         = 16;
    localparam int DEF_DEPTH_LOG2 = 9;
    localparam int DEF_PKT_WORDS  = 256;

    localparam int ZLP_W = 8;
endpackage

// File: rtl/fx2_ep_fifo.sv
// Synchronous FIFO with first-word-fall-through head, occupancy count and
// full/empty. Push is ignored when full and pop is ignored when empty.
module fx2_ep_fifo #(
    parameter int DW = 16,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          do_push, do_pop;

    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr[AW-1:0]];

    // storage write, no reset needed: contents are qualified by the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    // pointer update; MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/fx2_slave_fifo_emu.sv
// FX2 slave-FIFO responder: EP2 (host->master) and EP6 (master->host) with
// packet commit, auto-commit at PKT_WORDS and zero-length-packet counting.
module fx2_slave_fifo_emu
    import fx2_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int PKT_WORDS  = DEF_PKT_WORDS
) (
    input  logic             inclk0,
    input  logic             rst_n,
    input  logic [1:0]       faddr,
    input  logic             slrd,
    input  logic             slwr,
    input  logic             sloe,
    input  logic             pkt_end,
    inout  wire  [DW-1:0]    fdata,
    output logic             flaga,
    output logic             flagd,
    input  logic             h2d_valid,
    input  logic [DW-1:0]    h2d_data,
    output logic             h2d_ready,
    output logic             d2h_valid,
    output logic [DW-1:0]    d2h_data,
    output logic             d2h_last,
    input  logic             d2h_ready,
    output logic             ep6_ovf,
    output logic             ep2_udf,
    output logic [ZLP_W-1:0] zlp_cnt
);
    localparam int AW    = DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // ---------------- EP2 ----------------
    logic          ep2_sel, ep2_rd, ep2_empty, ep2_full;
    logic [DW-1:0] ep2_head;
    logic [AW:0]   ep2_cnt;

    assign ep2_sel   = (faddr == FADDR_EP2);
    assign ep2_rd    = ep2_sel & ~slrd;
    assign h2d_ready = ~ep2_full;
    assign flaga     = (ep2_cnt != '0);
    assign fdata     = (!sloe && ep2_sel && !ep2_empty) ? ep2_head : {DW{1'bz}};

    fx2_ep_fifo #(.DW(DW), .AW(AW)) u_ep2 (
        .clk   (inclk0),
        .rst_n (rst_n),
        .push  (h2d_valid),
        .din   (h2d_data),
        .pop   (ep2_rd),
        .dout  (ep2_head),
        .count (ep2_cnt),
        .empty (ep2_empty),
        .full  (ep2_full)
    );

    // sticky underflow on read strobe against an empty EP2
    always_ff @(posedge inclk0 or negedge rst_n) begin
        if (!rst_n)                ep2_udf <= 1'b0;
        else if (ep2_rd && ep2_empty) ep2_udf <= 1'b1;
    end

    // ---------------- EP6 ----------------
    logic [DW-1:0]    ep6_mem [DEPTH];
    logic [DEPTH-1:0] ep6_tag;
    logic [PW-1:0]    wptr, cptr, rptr, wptr_m1, ep6_cnt, uncm;
    logic             ep6_sel, wr_req, pe_req, ep6_full, ep6_push, ep6_pop, auto_c;

    assign ep6_sel  = (faddr == FADDR_EP6);
    assign wr_req   = ep6_sel & ~slwr;
    assign pe_req   = ep6_sel & ~pkt_end;
    assign ep6_cnt  = wptr - rptr;
    assign uncm     = wptr - cptr;
    assign wptr_m1  = wptr - PW'(1);
    assign ep6_full = (ep6_cnt == PW'(DEPTH));
    assign flagd    = ~ep6_full;
    assign ep6_push = wr_req & ~ep6_full;
    assign auto_c   = ep6_push && (uncm == PW'(PKT_WORDS - 1));

    assign d2h_valid = (rptr != cptr);
    assign d2h_data  = ep6_mem[rptr[AW-1:0]];
    assign d2h_last  = d2h_valid & ep6_tag[rptr[AW-1:0]];
    assign ep6_pop   = d2h_valid & d2h_ready;

    // EP6 storage write from the master bus
    always_ff @(posedge inclk0) begin
        if (ep6_push) ep6_mem[wptr[AW-1:0]] <= fdata;
    end

    // EP6 pointers, last tags, commit handling and sticky status
    always_ff @(posedge inclk0 or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            cptr    <= '0;
            rptr    <= '0;
            ep6_tag <= '0;
            ep6_ovf <= 1'b0;
            zlp_cnt <= '0;
        end else begin
            // the popped slot is never the one tagged below in the same cycle
            if (ep6_pop) begin
                ep6_tag[rptr[AW-1:0]] <= 1'b0;
                rptr <= rptr + 1'b1;
            end
            if (ep6_push) begin
                ep6_tag[wptr[AW-1:0]] <= auto_c | pe_req;
                wptr <= wptr + 1'b1;
            end
            if (wr_req && ep6_full) ep6_ovf <= 1'b1;

            if (ep6_push && (auto_c || pe_req)) begin
                cptr <= wptr + 1'b1;
            end else if (pe_req && uncm != '0) begin
                ep6_tag[wptr_m1[AW-1:0]] <= 1'b1;
                cptr <= wptr;
            end else if (pe_req) begin
                zlp_cnt <= zlp_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fx2_slave_fifo_emu.sv
// Scoreboard bench for fx2_slave_fifo_emu: EP2 reads, EP6 packets,
// auto-commit, ZLPs, overflow, underflow and mid-transfer reset.
module tb_fx2_slave_fifo_emu;
    logic        inclk0 = 1'b0;
    logic        rst_n;
    logic [1:0]  faddr;
    logic        slrd, slwr, sloe, pkt_end;
    wire  [15:0] fdata;
    logic        flaga, flagd;
    logic        h2d_valid, h2d_ready;
    logic [15:0] h2d_data;
    logic        d2h_valid, d2h_last, d2h_ready;
    logic [15:0] d2h_data;
    logic        ep6_ovf, ep2_udf;
    logic [7:0]  zlp_cnt;

    logic [15:0] tb_drv;
    logic        tb_oe;

    // master-side bus driver; pullups make an undriven bus read all-ones
    assign fdata = tb_oe ? tb_drv : 16'bz;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup pu (fdata[i]);
    end

    always #5 inclk0 = ~inclk0;

    fx2_slave_fifo_emu dut (
        .inclk0(inclk0), .rst_n(rst_n), .faddr(faddr), .slrd(slrd), .slwr(slwr),
        .sloe(sloe), .pkt_end(pkt_end), .fdata(fdata), .flaga(flaga), .flagd(flagd),
        .h2d_valid(h2d_valid), .h2d_data(h2d_data), .h2d_ready(h2d_ready),
        .d2h_valid(d2h_valid), .d2h_data(d2h_data), .d2h_last(d2h_last),
        .d2h_ready(d2h_ready), .ep6_ovf(ep6_ovf), .ep2_udf(ep2_udf), .zlp_cnt(zlp_cnt)
    );

    int nvec = 0;
    int nmis = 0;

    logic [15:0] ep2_q [$];
    logic [15:0] stage [$];
    logic [16:0] d2h_q [$];
    int          occ = 0;
    int          zlp_exp = 0;
    bit          ovf_exp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge inclk0);
        #1;
    endtask

    task automatic commit();
        for (int i = 0; i < stage.size(); i++)
            d2h_q.push_back({(i == stage.size() - 1), stage[i]});
        stage.delete();
    endtask

    task automatic pe_model();
        if (stage.size() > 0) commit();
        else zlp_exp++;
    endtask

    // one master write cycle to EP6, optionally with pkt_end in the same cycle
    task automatic wr(input logic [15:0] d, input bit pe);
        faddr = 2'b10; sloe = 1'b1; slwr = 1'b0; pkt_end = ~pe;
        tb_drv = d; tb_oe = 1'b1;
        if (occ < 512) begin
            stage.push_back(d);
            occ++;
            if (pe || stage.size() == 256) commit();
        end else begin
            ovf_exp = 1'b1;
            if (pe) pe_model();
        end
        tick();
        slwr = 1'b1; pkt_end = 1'b1; tb_oe = 1'b0;
    endtask

    task automatic pend();
        faddr = 2'b10; pkt_end = 1'b0;
        pe_model();
        tick();
        pkt_end = 1'b1;
    endtask

    task automatic drain();
        logic [16:0] e;
        d2h_ready = 1'b1;
        for (int c = 0; c < 3000 && d2h_q.size() > 0; c++) begin
            if (d2h_valid) begin
                e = d2h_q.pop_front();
                chk("d2h_word", {15'b0, d2h_last, d2h_data}, {15'b0, e});
                occ--;
            end
            tick();
        end
        if (d2h_q.size() != 0) chk("drain_timeout", d2h_q.size(), 0);
        d2h_ready = 1'b0;
        chk("d2h_idle", d2h_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; faddr = 2'b11; slrd = 1'b1; slwr = 1'b1; sloe = 1'b1;
        pkt_end = 1'b1; tb_drv = '0; tb_oe = 1'b0;
        h2d_valid = 1'b0; h2d_data = '0; d2h_ready = 1'b0;
        tick(); tick();
        chk("rst_flaga", flaga, 0);
        chk("rst_flagd", flagd, 1);
        chk("rst_h2d_ready", h2d_ready, 1);
        chk("rst_d2h_valid", d2h_valid, 0);
        chk("rst_d2h_last", d2h_last, 0);
        chk("rst_ovf", ep6_ovf, 0);
        chk("rst_udf", ep2_udf, 0);
        chk("rst_zlp", zlp_cnt, 0);
        chk("rst_fdata_z", fdata, 16'hFFFF);
        rst_n = 1'b1;
        tick();

        // EP2: host loads four words, master reads them back
        for (int i = 0; i < 4; i++) begin
            h2d_valid = 1'b1; h2d_data = 16'h0100 + 16'(i);
            ep2_q.push_back(h2d_data);
            tick();
            h2d_valid = 1'b0;
            chk("ep2_flaga_set", flaga, 1);
        end
        faddr = 2'b00; sloe = 1'b0; slrd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ep2_fdata", fdata, ep2_q.pop_front());
            tick();
        end
        slrd = 1'b1;
        #1;
        chk("ep2_flaga_clr", flaga, 0);
        chk("ep2_udf_clean", ep2_udf, 0);
        chk("ep2_fdata_z", fdata, 16'hFFFF);
        slrd = 1'b0;
        tick();
        slrd = 1'b1; sloe = 1'b1; faddr = 2'b11;
        chk("ep2_udf_set", ep2_udf, 1);

        // EP6: 120-word packet closed by pkt_end
        for (int i = 0; i < 120; i++) wr({8'(2*i+1), 8'(2*i)}, 0);
        pend();
        drain();
        chk("zlp_after_pkt", zlp_cnt, zlp_exp);

        // EP6: 256 words auto-commit, then a lone pkt_end is a ZLP
        for (int i = 0; i < 256; i++) wr(16'h2000 + 16'(i), 0);
        drain();
        pend();
        chk("zlp_one", zlp_cnt, zlp_exp);
        chk("zlp_one_abs", zlp_cnt, 1);

        // EP6: write with pkt_end in the same cycle after 3 words
        for (int i = 0; i < 3; i++) wr(16'h3000 + 16'(i), 0);
        wr(16'h3003, 1);
        chk("same_cycle_zlp", zlp_cnt, zlp_exp);
        drain();

        // EP6: fill to 512 with the host stalled, then overflow
        for (int i = 0; i < 511; i++) wr(16'h4000 + 16'(i), 0);
        chk("flagd_511", flagd, 1);
        wr(16'h41FF, 0);
        chk("flagd_full", flagd, 0);
        chk("ovf_before", ep6_ovf, 0);
        wr(16'h5555, 0);
        chk("ovf_set", ep6_ovf, ovf_exp);
        drain();
        chk("flagd_free", flagd, 1);

        // EP2 fills to 512 and deasserts h2d_ready
        h2d_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            h2d_data = 16'h6000 + 16'(i);
            tick();
        end
        h2d_valid = 1'b0;
        chk("ep2_full", h2d_ready, 0);

        // reset during an EP6 transfer with 50 uncommitted words
        for (int i = 0; i < 50; i++) wr(16'h7000 + 16'(i), 0);
        faddr = 2'b10; slwr = 1'b0; tb_drv = 16'h7777; tb_oe = 1'b1;
        rst_n = 1'b0;
        #2;
        tb_oe = 1'b0; slwr = 1'b1;
        chk("rst_mid_d2h_valid", d2h_valid, 0);
        chk("rst_mid_flagd", flagd, 1);
        chk("rst_mid_flaga", flaga, 0);
        chk("rst_mid_h2d_ready", h2d_ready, 1);
        faddr = 2'b00; sloe = 1'b0;
        #1;
        chk("rst_mid_fdata_z", fdata, 16'hFFFF);
        stage.delete(); d2h_q.delete(); occ = 0; zlp_exp = 0; ovf_exp = 0;
        tick();
        rst_n = 1'b1; sloe = 1'b1; faddr = 2'b11;
        tick();
        chk("rst_mid_zlp", zlp_cnt, 0);
        chk("rst_mid_ovf", ep6_ovf, 0);
        for (int i = 0; i < 5; i++) wr(16'hA000 + 16'(i), 0);
        wr(16'hA005, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
